// File: rtl/collision_detector.sv
// Hit detector between the player and one obstacle: debounces bounding-box overlap
// over game ticks, then tracks hits, lives, invulnerability cooldown and game over.
module collision_detector #(
  parameter logic [9:0] SCREEN_W       = 10'd640,
  parameter logic [2:0] CONFIRM_TICKS  = 3'd2,
  parameter logic [7:0] COOLDOWN_TICKS = 8'd12,
  parameter logic [2:0] LIVES          = 3'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_en,
  input  logic       restart,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [9:0] player_w,
  input  logic [9:0] player_h,
  input  logic [9:0] obstacle_x_pos,
  input  logic [9:0] obstacle_y_pos,
  input  logic [9:0] obstacle_width,
  input  logic [9:0] obstacle_height,
  output logic       collision,
  output logic       invulnerable,
  output logic [2:0] lives,
  output logic [3:0] hit_count,
  output logic       game_over
);

  typedef enum logic [2:0] {
    ARMED    = 3'd0,
    CONFIRM  = 3'd1,
    HIT      = 3'd2,
    COOLDOWN = 3'd3,
    OVER     = 3'd4
  } state_t;

  state_t     state, state_n;
  logic [2:0] confirm_cnt, confirm_n;
  logic [7:0] cooldown_cnt, cooldown_n;
  logic       collision_n, invulnerable_n, game_over_n;
  logic [2:0] lives_n;
  logic [3:0] hit_count_n;
  logic       enter_hit;

  // 11-bit extents so box edges near the 10-bit limit cannot wrap
  logic [10:0] px_end, py_end, ox_end, oy_end;
  logic        overlap;

  assign px_end = {1'b0, player_x} + {1'b0, player_w};
  assign py_end = {1'b0, player_y} + {1'b0, player_h};
  assign ox_end = {1'b0, obstacle_x_pos} + {1'b0, obstacle_width};
  assign oy_end = {1'b0, obstacle_y_pos} + {1'b0, obstacle_height};

  assign overlap = ({1'b0, player_x} < ox_end) &&
                   ({1'b0, obstacle_x_pos} < px_end) &&
                   ({1'b0, player_y} < oy_end) &&
                   ({1'b0, obstacle_y_pos} < py_end) &&
                   (obstacle_x_pos < SCREEN_W);

  always_comb begin
    state_n        = state;
    confirm_n      = confirm_cnt;
    cooldown_n     = cooldown_cnt;
    collision_n    = collision;
    invulnerable_n = invulnerable;
    game_over_n    = game_over;
    lives_n        = lives;
    hit_count_n    = hit_count;
    enter_hit      = 1'b0;

    if (game_en) begin
      if (restart) begin
        state_n        = ARMED;
        confirm_n      = '0;
        cooldown_n     = '0;
        collision_n    = 1'b0;
        invulnerable_n = 1'b0;
        game_over_n    = 1'b0;
        lives_n        = LIVES;
        hit_count_n    = '0;
      end else begin
        unique case (state)
          ARMED: begin
            if (overlap) begin
              confirm_n = 3'd1;
              if (3'd1 >= CONFIRM_TICKS) enter_hit = 1'b1;
              else                       state_n   = CONFIRM;
            end
          end
          CONFIRM: begin
            if (overlap) begin
              confirm_n = confirm_cnt + 3'd1;
              if (confirm_cnt + 3'd1 >= CONFIRM_TICKS) enter_hit = 1'b1;
            end else begin
              confirm_n = '0;
              state_n   = ARMED;
            end
          end
          HIT: begin
            collision_n = 1'b0;
            if (lives == 3'd0) begin
              state_n        = OVER;
              game_over_n    = 1'b1;
              invulnerable_n = 1'b0;
            end else begin
              state_n = COOLDOWN;
            end
          end
          COOLDOWN: begin
            cooldown_n = cooldown_cnt + 8'd1;
            if (cooldown_cnt + 8'd1 >= COOLDOWN_TICKS) begin
              invulnerable_n = 1'b0;
              confirm_n      = '0;
              state_n        = ARMED;
            end
          end
          OVER: begin
            game_over_n    = 1'b1;
            collision_n    = 1'b0;
            invulnerable_n = 1'b0;
          end
          default: begin
            state_n        = ARMED;
            confirm_n      = '0;
            cooldown_n     = '0;
            collision_n    = 1'b0;
            invulnerable_n = 1'b0;
          end
        endcase

        // Hit entry is shared by ARMED (single-tick confirm) and CONFIRM
        if (enter_hit) begin
          state_n        = HIT;
          collision_n    = 1'b1;
          invulnerable_n = 1'b1;
          cooldown_n     = '0;
          lives_n        = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
          hit_count_n    = (hit_count == 4'd15) ? 4'd15 : hit_count + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ARMED;
      confirm_cnt  <= '0;
      cooldown_cnt <= '0;
      collision    <= 1'b0;
      invulnerable <= 1'b0;
      game_over    <= 1'b0;
      lives        <= LIVES;
      hit_count    <= '0;
    end else begin
      state        <= state_n;
      confirm_cnt  <= confirm_n;
      cooldown_cnt <= cooldown_n;
      collision    <= collision_n;
      invulnerable <= invulnerable_n;
      game_over    <= game_over_n;
      lives        <= lives_n;
      hit_count    <= hit_count_n;
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Directed plus randomized bench for collision_detector against a tick-level
// reference model of hits, lives and invulnerability windows.
module tb_collision_detector;

  localparam int CONF = 2;
  localparam int COOL = 12;
  localparam int LIV  = 3;
  localparam int SW   = 640;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       game_en = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] player_x = '0, player_y = '0, player_w = '0, player_h = '0;
  logic [9:0] obstacle_x_pos = '0, obstacle_y_pos = '0;
  logic [9:0] obstacle_width = '0, obstacle_height = '0;
  logic       collision, invulnerable, game_over;
  logic [2:0] lives;
  logic [3:0] hit_count;

  int n_vec = 0;
  int n_err = 0;

  // reference model: streak of overlapping ticks, remaining invulnerable ticks
  int m_lives, m_hits, m_streak, m_cool_left;
  bit m_col, m_inv, m_over, m_just_hit;

  int rx, rpx, rpw;

  always #5 clk = ~clk;

  collision_detector #(
    .SCREEN_W(10'd640),
    .CONFIRM_TICKS(3'd2),
    .COOLDOWN_TICKS(8'd12),
    .LIVES(3'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .game_en(game_en),
    .restart(restart),
    .player_x(player_x),
    .player_y(player_y),
    .player_w(player_w),
    .player_h(player_h),
    .obstacle_x_pos(obstacle_x_pos),
    .obstacle_y_pos(obstacle_y_pos),
    .obstacle_width(obstacle_width),
    .obstacle_height(obstacle_height),
    .collision(collision),
    .invulnerable(invulnerable),
    .lives(lives),
    .hit_count(hit_count),
    .game_over(game_over)
  );

  function automatic bit boxes_overlap();
    int px = int'(player_x), py = int'(player_y);
    int pw = int'(player_w), ph = int'(player_h);
    int ox = int'(obstacle_x_pos), oy = int'(obstacle_y_pos);
    int ow = int'(obstacle_width), oh = int'(obstacle_height);
    return (px < ox + ow) && (ox < px + pw) && (py < oy + oh) && (oy < py + ph) && (ox < SW);
  endfunction

  task automatic model_reset();
    m_lives = LIV; m_hits = 0; m_streak = 0; m_cool_left = 0;
    m_col = 0; m_inv = 0; m_over = 0; m_just_hit = 0;
  endtask

  task automatic model_tick(input bit ov, input bit rs);
    if (rs) begin
      model_reset();
    end else if (m_over) begin
      m_col = 0; m_inv = 0;
    end else if (m_just_hit) begin
      m_just_hit = 0;
      m_col = 0;
      if (m_lives == 0) begin m_over = 1; m_inv = 0; end
      else m_cool_left = COOL;
    end else if (m_cool_left > 0) begin
      m_cool_left--;
      if (m_cool_left == 0) begin m_inv = 0; m_streak = 0; end
    end else begin
      m_streak = ov ? m_streak + 1 : 0;
      if (m_streak >= CONF) begin
        m_col = 1; m_inv = 1; m_just_hit = 1; m_streak = 0;
        if (m_lives > 0) m_lives--;
        if (m_hits < 15) m_hits++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".collision"},    {3'b0, collision},    {3'b0, m_col});
    check({where, ".invulnerable"}, {3'b0, invulnerable}, {3'b0, m_inv});
    check({where, ".lives"},        {1'b0, lives},        4'(m_lives));
    check({where, ".hit_count"},    hit_count,            4'(m_hits));
    check({where, ".game_over"},    {3'b0, game_over},    {3'b0, m_over});
  endtask

  task automatic tick(input bit rs, input string where);
    bit ov;
    @(negedge clk);
    restart = rs;
    game_en = 1'b1;
    ov = boxes_overlap();
    @(posedge clk);
    #1;
    game_en = 1'b0;
    restart = 1'b0;
    model_tick(ov, rs);
    check_all(where);
  endtask

  task automatic idle(input int n, input string where);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_all(where);
    end
  endtask

  task automatic set_player(input int x, input int y, input int w, input int h);
    player_x = 10'(x); player_y = 10'(y); player_w = 10'(w); player_h = 10'(h);
  endtask

  task automatic set_obs(input int x, input int y, input int w, input int h);
    obstacle_x_pos = 10'(x); obstacle_y_pos = 10'(y);
    obstacle_width = 10'(w); obstacle_height = 10'(h);
  endtask

  initial begin
    model_reset();
    set_player(100, 285, 30, 30);
    set_obs(640, 290, 20, 20);
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // off-screen obstacle never hits
    for (int i = 0; i < 5; i++) tick(0, "offscreen");

    // confirmed hit, then overlap held through and past the cooldown
    set_obs(110, 290, 20, 20);
    tick(0, "confirm1");
    idle(2, "confirm1_hold");
    tick(0, "hit1");
    idle(3, "hit1_hold");
    tick(0, "hit1_fall");
    for (int i = 0; i < 18; i++) tick(0, "cooldown_held");

    tick(1, "restart1");

    // broken run with touching edge on the gap tick
    set_obs(110, 290, 20, 20); tick(0, "gap_a");
    set_obs(130, 290, 20, 20); tick(0, "gap_touch");
    set_obs(110, 290, 20, 20); tick(0, "gap_b");
    set_obs(640, 290, 20, 20); tick(0, "gap_off");
    set_obs(110, 290, 20, 20); tick(0, "gap_c");
    set_obs(700, 290, 20, 20); tick(0, "gap_off2");

    // three hits to game over, then further overlap does nothing
    set_obs(110, 290, 20, 20);
    for (int i = 0; i < 50; i++) tick(0, "to_over");
    tick(1, "restart2");

    // async reset during cooldown
    tick(0, "ar_c1");
    tick(0, "ar_hit");
    tick(0, "ar_to_cool");
    for (int i = 0; i < 5; i++) tick(0, "ar_cool");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    tick(0, "post_rst1");
    tick(0, "post_rst_hit");

    // long pause with full overlap: nothing moves
    set_obs(0, 0, 1000, 1000);
    idle(1000, "pause");
    tick(0, "after_pause");

    // randomized positions, restarts and gaps between ticks
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        rpx = $urandom_range(0, 600);
        rpw = $urandom_range(4, 60);
        set_player(rpx, $urandom_range(0, 450), rpw, $urandom_range(4, 60));
        case ($urandom_range(3))
          0: rx = $urandom_range(0, 900);
          1: rx = rpx + rpw;
          default: begin
            rx = rpx + $urandom_range(0, rpw + 20) - 10;
            if (rx < 0) rx = 0;
          end
        endcase
        set_obs(rx, int'(player_y) + $urandom_range(0, 40) - 20 < 0 ? 0 :
                int'(player_y) + $urandom_range(0, 40) - 20,
                $urandom_range(1, 60), $urandom_range(1, 60));
      end
      tick(($urandom_range(39) == 0), "rand");
      idle($urandom_range(0, 2), "rand_gap");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
